// File: rtl/switch_poll_pkg.sv
// Shared constants and types for the switch polling controller.
package switch_poll_pkg;

  // CPU-visible register addresses
  localparam logic [1:0] REG_STATE = 2'd0;
  localparam logic [1:0] REG_EDGE  = 2'd1;
  localparam logic [1:0] REG_MASK  = 2'd2;
  localparam logic [1:0] REG_CTRL  = 2'd3;

  // Bit position of the poll enable inside CTRL
  localparam int unsigned CTRL_EN_BIT = 0;

  // Debounce counter width; wide enough for STABLE_CNT up to 15
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    WAIT = 2'd0,
    REQ  = 2'd1,
    CAP  = 2'd2
  } poll_state_t;

endpackage

// File: rtl/switch_debounce.sv
// Debounce filter: accepts a new switch value once it has been sampled
// STABLE_CNT times in a row, and reports which bits flipped on acceptance.
module switch_debounce import switch_poll_pkg::*; #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned STABLE_CNT = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_sample_vld,
  input  logic [WIDTH-1:0] i_sample,
  output logic [WIDTH-1:0] o_state,
  output logic [WIDTH-1:0] o_change
);

  localparam logic [CNT_W-1:0] CntTarget = CNT_W'(STABLE_CNT);

  logic [WIDTH-1:0] r_cand;
  logic [WIDTH-1:0] r_state;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0] w_cand_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_accept;

  // Next candidate/count from the incoming sample; accept on the resulting count
  always_comb begin
    w_cand_nxt = r_cand;
    w_cnt_nxt  = r_cnt;
    if (i_sample == r_cand) begin
      if (r_cnt != CntTarget) w_cnt_nxt = r_cnt + CNT_W'(1);
    end else begin
      w_cand_nxt = i_sample;
      w_cnt_nxt  = CNT_W'(1);
    end
    w_accept = i_sample_vld && (w_cnt_nxt == CntTarget) && (w_cand_nxt != r_state);
    o_change = w_accept ? (r_state ^ w_cand_nxt) : '0;
  end

  // Filter state only advances on a fresh sample
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cand  <= '0;
      r_cnt   <= '0;
      r_state <= '0;
    end else if (i_sample_vld) begin
      r_cand <= w_cand_nxt;
      r_cnt  <= w_cnt_nxt;
      if (w_accept) r_state <= w_cand_nxt;
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/switch_poll_ctrl.sv
// Periodically reads the switch PIO, debounces the value and exposes it with
// sticky change flags and a maskable level interrupt over an Avalon-MM slave.
module switch_poll_ctrl import switch_poll_pkg::*; #(
  parameter int unsigned POLL_DIV   = 50000,
  parameter int unsigned STABLE_CNT = 4,
  parameter int unsigned WIDTH      = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [1:0]  m_address,
  output logic        m_read,
  input  logic [31:0] m_readdata,
  input  logic [1:0]  s_address,
  input  logic        s_read,
  input  logic        s_write,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic        irq
);

  localparam int unsigned     DivW    = $clog2(POLL_DIV);
  localparam logic [DivW-1:0] DivLast = DivW'(POLL_DIV - 1);

  poll_state_t      r_poll, w_poll_nxt;
  logic [DivW-1:0]  r_div, w_div_nxt;
  logic [WIDTH-1:0] r_sample;
  logic             r_sample_vld;
  logic [WIDTH-1:0] r_edge;
  logic [WIDTH-1:0] r_mask;
  logic             r_enable;

  logic [WIDTH-1:0] w_state;
  logic [WIDTH-1:0] w_change;
  logic [WIDTH-1:0] w_w1c;
  logic [31:0]      w_rdata;
  logic             w_unused;

  // Divider runs whenever enabled, and always while a read is in flight so an
  // in-progress transaction keeps the period exact; disabled WAIT parks it.
  always_comb begin
    w_poll_nxt = r_poll;
    w_div_nxt  = r_div;
    if (r_enable || (r_poll != WAIT)) begin
      w_div_nxt = (r_div == DivLast) ? '0 : r_div + DivW'(1);
    end
    case (r_poll)
      WAIT:    if (r_enable && (r_div == DivLast)) w_poll_nxt = REQ;
      REQ:     w_poll_nxt = CAP;
      CAP:     w_poll_nxt = WAIT;
      default: w_poll_nxt = WAIT;
    endcase
  end

  // Poll FSM, divider and PIO data capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_poll       <= WAIT;
      r_div        <= '0;
      r_sample     <= '0;
      r_sample_vld <= 1'b0;
    end else begin
      r_poll       <= w_poll_nxt;
      r_div        <= w_div_nxt;
      r_sample_vld <= (r_poll == CAP);
      if (r_poll == CAP) r_sample <= m_readdata[WIDTH-1:0];
    end
  end

  assign m_read    = (r_poll == REQ);
  assign m_address = 2'b00;

  switch_debounce #(
    .WIDTH      (WIDTH),
    .STABLE_CNT (STABLE_CNT)
  ) u_debounce (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_sample_vld (r_sample_vld),
    .i_sample     (r_sample),
    .o_state      (w_state),
    .o_change     (w_change)
  );

  assign w_w1c = (s_write && (s_address == REG_EDGE)) ? s_writedata[WIDTH-1:0] : '0;

  // Register read mux; unused bits read as zero
  always_comb begin
    w_rdata = '0;
    case (s_address)
      REG_STATE: w_rdata[WIDTH-1:0] = w_state;
      REG_EDGE:  w_rdata[WIDTH-1:0] = r_edge;
      REG_MASK:  w_rdata[WIDTH-1:0] = r_mask;
      REG_CTRL:  w_rdata[CTRL_EN_BIT] = r_enable;
      default:   w_rdata = '0;
    endcase
  end

  // Register file, sticky edges (a new set beats a same-cycle clear) and irq
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_edge     <= '0;
      r_mask     <= '0;
      r_enable   <= 1'b1;
      s_readdata <= '0;
      irq        <= 1'b0;
    end else begin
      r_edge <= (r_edge & ~w_w1c) | w_change;
      if (s_write && (s_address == REG_MASK)) r_mask <= s_writedata[WIDTH-1:0];
      if (s_write && (s_address == REG_CTRL)) r_enable <= s_writedata[CTRL_EN_BIT];
      if (s_read) s_readdata <= w_rdata;
      irq <= |(r_edge & r_mask);
    end
  end

  assign w_unused = ^{m_readdata[31:WIDTH], s_writedata[31:WIDTH]};

endmodule
